// File: rtl/ring_tick_gen.sv
// ring_tick_gen: prescaled advance-pulse generator with run/single-step control and ring phase tracking
module ring_tick_gen #(
  parameter int DIV_W  = 24,
  parameter int PHASES = 6
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [DIV_W-1:0] DIV,
  input  logic             RUN,
  input  logic             STEP_REQ,
  output logic             STEP_ACK,
  output logic             CE,
  output logic [2:0]       PHASE,
  output logic             WRAP
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_ACK} state_t;
  localparam logic [2:0] LAST = 3'(PHASES - 1);
  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ce_q, ce_d, ack_q, ack_d, wrap_q, wrap_d;
  logic [2:0]       phase_q, phase_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    ce_d    = 1'b0;
    ack_d   = 1'b0;
    case (state_q)
      S_IDLE: state_d = RUN ? S_RUN : (STEP_REQ ? S_STEP : S_IDLE);
      S_RUN: begin
        ce_d    = RUN && (cnt_q >= DIV);
        cnt_d   = (RUN && (cnt_q < DIV)) ? cnt_q + DIV_W'(1) : '0;
        state_d = RUN ? S_RUN : S_IDLE;
      end
      S_STEP: begin
        ce_d    = 1'b1;
        state_d = S_ACK;
      end
      S_ACK: begin
        ack_d   = STEP_REQ;
        state_d = STEP_REQ ? S_ACK : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    phase_d = ce_d ? ((phase_q == LAST) ? 3'd0 : phase_q + 3'd1) : phase_q;
    wrap_d  = ce_d && (phase_q == LAST);
  end
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ce_q    <= 1'b0;
      ack_q   <= 1'b0;
      phase_q <= 3'd0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
      ack_q   <= ack_d;
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
    end
  end
  assign CE       = ce_q;
  assign STEP_ACK = ack_q;
  assign PHASE    = phase_q;
  assign WRAP     = wrap_q;
endmodule

// File: tb/tb_ring_tick_gen.sv
// tb_ring_tick_gen: directed stimulus with a cycle model of run/step behaviour and literal expectations
module tb_ring_tick_gen;
  localparam int DIV_W  = 24;
  localparam int PHASES = 6;
  logic             CLK = 1'b0, RESETN = 1'b0, RUN = 1'b0, STEP_REQ = 1'b0;
  logic [DIV_W-1:0] DIV = '0;
  logic             STEP_ACK, CE, WRAP;
  logic [2:0]       PHASE;
  int checks = 0, errors = 0;
  int m_mode, m_cnt, m_ticks, e_phase, quiet;
  bit m_tick, e_ce, e_ack, e_wrap;
  always #5 CLK = ~CLK;
  ring_tick_gen #(.DIV_W(DIV_W), .PHASES(PHASES)) dut (
    .CLK(CLK), .RESETN(RESETN), .DIV(DIV), .RUN(RUN), .STEP_REQ(STEP_REQ),
    .STEP_ACK(STEP_ACK), .CE(CE), .PHASE(PHASE), .WRAP(WRAP)
  );
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic edges(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  // Model modes: 0 idle, 1 running, 2 stepping, 3 acknowledging; phase is total ticks modulo ring length
  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      m_mode = 0; m_cnt = 0; m_ticks = 0;
      e_ce = 0; e_ack = 0; e_wrap = 0; e_phase = 0;
    end else begin
      m_tick = 0;
      e_ack  = 0;
      if (m_mode == 0) begin
        if (RUN) begin m_mode = 1; m_cnt = 0; end
        else if (STEP_REQ) m_mode = 2;
      end else if (m_mode == 1) begin
        if (!RUN) begin m_mode = 0; m_cnt = 0; end
        else if (m_cnt >= int'(DIV)) begin m_cnt = 0; m_tick = 1; end
        else m_cnt = m_cnt + 1;
      end else if (m_mode == 2) begin
        m_tick = 1; m_mode = 3;
      end else begin
        e_ack = STEP_REQ;
        if (!STEP_REQ) m_mode = 0;
      end
      if (m_tick) m_ticks = m_ticks + 1;
      e_ce    = m_tick;
      e_phase = m_ticks % PHASES;
      e_wrap  = m_tick && (e_phase == 0);
    end
  end
  always @(posedge CLK) begin
    #1;
    chk("model_ce", CE, e_ce);
    chk("model_phase", PHASE, e_phase);
    chk("model_wrap", WRAP, e_wrap);
    chk("model_ack", STEP_ACK, e_ack);
  end
  task automatic pulse_reset();
    @(negedge CLK);
    RESETN = 1'b0;
    RUN = 1'b0;
    #1;
    chk("rst_now_ce", CE, 0);
    chk("rst_now_phase", PHASE, 0);
    chk("rst_now_ack", STEP_ACK, 0);
    @(negedge CLK);
    RESETN = 1'b1;
  endtask
  task automatic handshake(input bit keep);
    @(negedge CLK);
    STEP_REQ = 1'b1;
    for (int k = 0; k < 20 && !STEP_ACK; k++) edges(1);
    chk("hs_ack_rise", STEP_ACK, 1);
    if (!keep) begin
      @(negedge CLK);
      STEP_REQ = 1'b0;
      for (int k = 0; k < 20 && STEP_ACK; k++) edges(1);
      chk("hs_ack_fall", STEP_ACK, 0);
    end
  endtask
  initial begin
    DIV = 24'd3;
    repeat (2) @(negedge CLK);
    chk("rst_ce", CE, 0);
    chk("rst_phase", PHASE, 0);
    chk("rst_ack", STEP_ACK, 0);
    chk("rst_wrap", WRAP, 0);
    RESETN = 1'b1;
    @(negedge CLK); RUN = 1'b1;
    edges(5); chk("a_ce1", CE, 1); chk("a_ph1", PHASE, 1);
    edges(3); chk("a_gap", CE, 0);
    edges(1); chk("a_ce2", CE, 1); chk("a_ph2", PHASE, 2);
    edges(4); chk("a_ce3", CE, 1); chk("a_ph3", PHASE, 3);
    @(negedge CLK); RUN = 1'b0;
    edges(3); chk("a_idle", CE, 0);
    pulse_reset();
    @(negedge CLK); DIV = 24'd0; RUN = 1'b1;
    edges(2); chk("b_ce1", CE, 1); chk("b_ph1", PHASE, 1); chk("b_w1", WRAP, 0);
    edges(4); chk("b_ce5", CE, 1); chk("b_ph5", PHASE, 5); chk("b_w5", WRAP, 0);
    edges(1); chk("b_ce6", CE, 1); chk("b_ph6", PHASE, 0); chk("b_w6", WRAP, 1);
    @(negedge CLK); RUN = 1'b0;
    edges(1); chk("b_stop", CE, 0);
    @(negedge CLK); DIV = 24'd2; STEP_REQ = 1'b1;
    edges(2); chk("c_ce", CE, 1); chk("c_ph", PHASE, 1); chk("c_ack0", STEP_ACK, 0);
    edges(1); chk("c_ack1", STEP_ACK, 1); chk("c_ce_off", CE, 0);
    @(negedge CLK); RUN = 1'b1;
    edges(2); chk("c_ack_hold", STEP_ACK, 1); chk("c_run_ignored", CE, 0);
    @(negedge CLK); STEP_REQ = 1'b0;
    edges(1); chk("c_ack_drop", STEP_ACK, 0);
    edges(4); chk("c_run_ce", CE, 1); chk("c_run_ph", PHASE, 2);
    @(negedge CLK); RUN = 1'b0;
    edges(2);
    @(negedge CLK); DIV = 24'd5; RUN = 1'b1; STEP_REQ = 1'b1;
    edges(1); chk("d_no_ack", STEP_ACK, 0); chk("d_no_ce", CE, 0);
    edges(3);
    @(negedge CLK); RUN = 1'b0; STEP_REQ = 1'b0;
    quiet = 0;
    repeat (10) begin edges(1); quiet += int'(CE) + int'(STEP_ACK); end
    chk("d_quiet", quiet, 0);
    @(negedge CLK); DIV = 24'd10; RUN = 1'b1;
    edges(8);
    @(negedge CLK); DIV = 24'd4;
    edges(1); chk("e_lowered", CE, 1);
    edges(4); chk("e_gap", CE, 0);
    edges(1); chk("e_next", CE, 1);
    @(negedge CLK); RUN = 1'b0;
    edges(2);
    @(negedge CLK); DIV = 24'd2; RUN = 1'b1;
    edges(5);
    pulse_reset();
    quiet = 0;
    repeat (6) begin edges(1); quiet += int'(CE); end
    chk("f_quiet_after_rst", quiet, 0);
    handshake(1'b0);
    handshake(1'b0);
    handshake(1'b0);
    handshake(1'b1);
    chk("f_ph4", PHASE, 4);
    @(negedge CLK); RESETN = 1'b0;
    #1; chk("f_rst_ack", STEP_ACK, 0); chk("f_rst_ph", PHASE, 0); chk("f_rst_ce", CE, 0);
    @(negedge CLK); RESETN = 1'b1;
    edges(2); chk("f_restep_ce", CE, 1); chk("f_restep_ph", PHASE, 1);
    @(negedge CLK); STEP_REQ = 1'b0;
    edges(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ring_tick_gen.md
RING_TICK_GEN -- requirements
Module: ring_tick_gen

Interface
REQ-001 The block SHALL have parameter DIV_W, default 24, the width of the prescale divider.
REQ-002 The block SHALL have parameter PHASES, default 6, the ring length tracked by PHASE (legal range 2..8).
REQ-003 The block SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RESETN, input, 1 bit, reset, asynchronous and active-low.
REQ-005 The block SHALL have port DIV, input, DIV_W bits, terminal count; one advance per DIV+1 cycles.
REQ-006 The block SHALL have port RUN, input, 1 bit, level request for free-running advance.
REQ-007 The block SHALL have port STEP_REQ, input, 1 bit, single-step request (4-phase handshake).
REQ-008 The block SHALL have port STEP_ACK, output, 1 bit, single-step acknowledge.
REQ-009 The block SHALL have port CE, output, 1 bit, one-cycle advance pulse driving the downstream ring CE.
REQ-010 The block SHALL have port PHASE, output, 3 bits, ring position index 0..PHASES-1.
REQ-011 The block SHALL have port WRAP, output, 1 bit, pulse when PHASE wraps PHASES-1 -> 0.

Function
REQ-012 The FSM SHALL have states IDLE, RUN, STEP, ACK; all outputs SHALL be registered.
REQ-013 IDLE: divider count held at 0, CE=0, STEP_ACK=0.
REQ-014 IDLE, RUN=1 sampled: go to RUN with count=0; RUN has priority over a simultaneous STEP_REQ=1.
REQ-015 IDLE, RUN=0 and STEP_REQ=1: go to STEP.
REQ-016 RUN state: count increments each cycle; when count >= DIV, count -> 0 and CE is 1 in the following cycle.
REQ-017 Free-running CE SHALL be high exactly one cycle per DIV+1 cycles; first CE high DIV+1 cycles after the edge that entered RUN.
REQ-018 DIV=0 SHALL give CE high every cycle while in RUN.
REQ-019 DIV changed mid-count: the >= compare applies immediately; a lowered DIV below the current count SHALL cause a tick on the next compare.
REQ-020 RUN state, RUN=0 sampled: return to IDLE, count cleared, pending tick discarded, CE=0 next cycle.
REQ-021 STEP: CE SHALL be 1 for exactly one cycle, then go to ACK regardless of RUN.
REQ-022 ACK: STEP_ACK=1 held until STEP_REQ=0 is sampled, then STEP_ACK=0 and go to IDLE.
REQ-023 RUN asserted during STEP/ACK SHALL be ignored until IDLE is re-entered.
REQ-024 PHASE SHALL increment in the cycle CE is high, wrapping PHASES-1 -> 0.
REQ-025 WRAP SHALL be 1 coincident with the CE pulse that moves PHASE from PHASES-1 to 0; else 0.
REQ-026 PHASE SHALL hold its value across IDLE/RUN/STEP transitions; only reset clears it.
REQ-027 Divider arithmetic SHALL be unsigned DIV_W bits; count never exceeds max(DIV, previous count).

Reset
REQ-028 RESETN=0 SHALL immediately force state IDLE, count 0, CE=0, STEP_ACK=0, PHASE=0, WRAP=0.
REQ-029 Reset asserted mid-RUN or mid-handshake SHALL abort it; no CE is emitted after release until a new RUN/STEP_REQ.
REQ-030 Release of RESETN SHALL take effect at the first CLK edge at which it is sampled high; no sync inside the block.

Verification
REQ-031 DIV=3, RUN=1 held from edge 1 -> CE high in cycles after edges 5, 9, 13; PHASE 1,2,3.
REQ-032 DIV=0, RUN=1 for 6 CE pulses, PHASES=6 -> PHASE 1..5,0; WRAP high only on the 6th CE.
REQ-033 IDLE, STEP_REQ=1 -> one CE pulse, then STEP_ACK=1; STEP_REQ dropped -> STEP_ACK=0 next cycle; PHASE +1.
REQ-034 RUN and STEP_REQ rising same edge -> RUN wins, STEP_ACK stays 0; RUN dropped with DIV=5 at count 3 -> no CE emitted.
REQ-035 DIV=10, count reaches 7, DIV changed to 4 -> CE the next cycle, then every 5 cycles.
REQ-036 RESETN pulsed low in ACK with PHASE=4 -> STEP_ACK=0, PHASE=0 immediately; STEP_REQ still high after release -> new STEP cycle.
